exp_ram_arbiter: RTL
====================

# exp_ram_arbiter

Shares the single expansion-RAM (SDRAM) byte port between three requesters: port 0 is the REU, port 1 is the cartridge/GeoRAM mapper, and port 2 is the loader. It grants one access at a time in round-robin order and performs the SDRAM transaction. It then gives the winner a fixed-length `ram_cycle` window with stable read data. It sits between the requesters and the SDRAM controller's 8-bit side port.

## Interface
- `WIN_LEN`, 4: clocks per requester window; `cycle[g]` is high for exactly this many clocks.
- `TIMEOUT`, 63: maximum clocks to wait for `sd_ack` before the access is abandoned.
- `clk` in 1: system clock; everything is rising-edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req` in 3: per-port access pending.
  - A port holds `req` level-high, with its addr/we/dout stable, until its window ends.
- `addr0`/`addr1`/`addr2` in 25: byte address per port.
- `we` in 3: per-port write enable (1 = write).
- `dout0`/`dout1`/`dout2` in 8: per-port write data.
- `cycle` out 3: one-hot window strobe to the granted port.
- `din` out 8: shared read-data bus to all ports.
- `sd_req` out 1: one-clock request pulse to the SDRAM controller.
- `sd_addr` out 25: latched address for the granted access.
- `sd_we` out 1: latched write enable.
- `sd_din` out 8: latched write data to SDRAM.
- `sd_dout` in 8: SDRAM read data, valid with `sd_ack`.
- `sd_ack` in 1: one-clock completion pulse from the SDRAM controller.

## Operation
- **States:** IDLE, ISSUE, WAIT, WINDOW, GAP.
- **IDLE:** if any `req` is set, pick a grant `g` round-robin, starting at `last+1` mod 3 (`last` resets to 2, so port 0 wins first).
  - On the pick, latch `addr_g`/`we_g`/`dout_g` into `sd_addr`/`sd_we`/`sd_din`, set `last`←`g`, go to ISSUE.
- **ISSUE:** `sd_req`=1 for exactly one clock, clear the timeout counter, go to WAIT.
- **WAIT:** `sd_ack` is sampled starting the clock after ISSUE.
  - On `sd_ack`: for a read, `din`←`sd_dout`; for a write, `din` is unchanged. Go to WINDOW.
  - If the counter reaches TIMEOUT: `din`←8'hFF, go to WINDOW (the access is treated as done).
- **WINDOW:** `cycle[g]`=1 for WIN_LEN clocks (6-bit window counter), `din` held stable, then go to GAP.
- **GAP:** one clock with all `cycle`=0, then IDLE.
  - Requesters must drop `req` by the end of GAP unless they issue a new access. A `req` still high in IDLE is a new request.
- **Dropped request:** `req` falling after the grant does not abort; the access and window complete.
- **Late `sd_ack`:** an `sd_ack` arriving outside WAIT is ignored.
- **Write latching:** `sd_addr`/`sd_we`/`sd_din` change only on an IDLE grant.

## Timing
- **Reset values (asynchronous):** state=IDLE, `cycle`=0, `sd_req`=0, `sd_we`=0, `sd_addr`=0, `sd_din`=0, `din`=8'hFF, `last`=2, counters 0.
- **Handshake pacing**, with grant at IDLE clock t:
  - `sd_req` is high at t+1.
  - The earliest `sd_ack` is at t+2.
  - The window starts the clock after `sd_ack`.
  - The earliest next grant is t+3+WIN_LEN+1.
  - The minimum access period is 4+WIN_LEN clocks (8 with the default).
- **Read-data validity:** `din` is valid from the first `cycle` clock through the last one, so a requester may sample it on any window clock (the REU samples on the 4th).
- **Reset mid-operation:** all outputs return to reset values immediately and the pending access is dropped. `sd_req` must never be high across reset release.
- **Simultaneous requests:** with all three `req` set continuously, grants rotate 0,1,2,0,… and no port waits more than 2 foreign accesses.

## Structure
- Package `exp_ram_pkg`:
  - state enum `arb_state_t` {IDLE, ISSUE, WAIT, WINDOW, GAP}.
  - `NUM_REQ`=3, `ADDR_W`=25, `PORT_REU`=0, `PORT_CART`=1, `PORT_LOAD`=2.
- Sub-module `rr_pick3`, combinational: inputs `req[2:0]`, `last[1:0]`; outputs `any`, `grant[1:0]`.
- Top-level FSM, latches and counters: roughly 150–200 lines.

## Test plan
- **Single read:** `req`=3'b001, `addr0`=25'h1000010, `we`=0; `sd_ack` with `sd_dout`=8'h5A two clocks after `sd_req`.
  - Expect exactly one `sd_req`, `sd_addr`=25'h1000010, then `cycle`=3'b001 for 4 clocks with `din`=8'h5A on every one.
- **Write:** port 1, `addr1`=25'h0012345, `dout1`=8'hC3, `we[1]`=1.
  - Expect `sd_we`=1 and `sd_din`=8'hC3 at `sd_req`; `cycle`=3'b010 for 4 clocks; `din` unchanged.
- **Fairness:** all three `req` held high, 9 accesses with `sd_ack` 1 clock after `sd_req`.
  - Expect grant order 0,1,2,0,1,2,0,1,2 and an access period of 8 clocks.
- **Timeout:** `sd_ack` never asserted on a port-2 read.
  - Expect the window to start TIMEOUT+1 clocks after `sd_req` with `din`=8'hFF.
  - A later stray `sd_ack` is ignored.
- **Reset mid-window:** assert `reset_n`=0 on the 2nd `cycle` clock.
  - Expect `cycle`=0, `sd_req`=0 and `din`=8'hFF asynchronously.
  - After release with `req`=3'b111, port 0 is granted first.

Source files
------------

// File: rtl/exp_ram_pkg.sv
// Shared types and constants for the expansion-RAM arbiter.
// Three requesters are served: REU, cartridge/GeoRAM mapper and loader.
package exp_ram_pkg;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 25;

  localparam logic [1:0] PORT_REU  = 2'd0;
  localparam logic [1:0] PORT_CART = 2'd1;
  localparam logic [1:0] PORT_LOAD = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WINDOW,
    GAP
  } arb_state_t;

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker for three requesters.
// The search starts at the port after the last grant.
module rr_pick3
  import exp_ram_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic               any,
  output logic [1:0]         grant
);

  logic [1:0] p0, p1, p2;

  always_comb begin
    case (last)
      PORT_REU: begin
        p0 = PORT_CART;
        p1 = PORT_LOAD;
        p2 = PORT_REU;
      end
      PORT_CART: begin
        p0 = PORT_LOAD;
        p1 = PORT_REU;
        p2 = PORT_CART;
      end
      // last == 2 and the unused encoding both restart at port 0
      default: begin
        p0 = PORT_REU;
        p1 = PORT_CART;
        p2 = PORT_LOAD;
      end
    endcase
    any   = |req;
    grant = p2;
    if (req[p1]) grant = p1;
    if (req[p0]) grant = p0;
  end

endmodule

// File: rtl/exp_ram_arbiter.sv
// Round-robin arbiter sharing the SDRAM byte side port between REU, cartridge
// and loader; each access ends with a fixed-length window of stable read data.
module exp_ram_arbiter
  import exp_ram_pkg::*;
#(
  parameter int WIN_LEN = 4,
  parameter int TIMEOUT = 63
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [ADDR_W-1:0]  addr0,
  input  logic [ADDR_W-1:0]  addr1,
  input  logic [ADDR_W-1:0]  addr2,
  input  logic [NUM_REQ-1:0] we,
  input  logic [7:0]         dout0,
  input  logic [7:0]         dout1,
  input  logic [7:0]         dout2,
  output logic [NUM_REQ-1:0] cycle,
  output logic [7:0]         din,
  output logic               sd_req,
  output logic [ADDR_W-1:0]  sd_addr,
  output logic               sd_we,
  output logic [7:0]         sd_din,
  input  logic [7:0]         sd_dout,
  input  logic               sd_ack
);

  arb_state_t         state_q, state_d;
  logic [1:0]         last_q, last_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [NUM_REQ-1:0] cycle_q, cycle_d;
  logic [7:0]         din_q, din_d;
  logic               sd_req_q, sd_req_d;
  logic [ADDR_W-1:0]  sd_addr_q, sd_addr_d;
  logic               sd_we_q, sd_we_d;
  logic [7:0]         sd_din_q, sd_din_d;
  logic [5:0]         to_cnt_q, to_cnt_d;
  logic [5:0]         win_cnt_q, win_cnt_d;

  logic               pick_any;
  logic [1:0]         pick_grant;

  rr_pick3 u_pick (
    .req   (req),
    .last  (last_q),
    .any   (pick_any),
    .grant (pick_grant)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    cycle_d   = cycle_q;
    din_d     = din_q;
    sd_req_d  = 1'b0;
    sd_addr_d = sd_addr_q;
    sd_we_d   = sd_we_q;
    sd_din_d  = sd_din_q;
    to_cnt_d  = to_cnt_q;
    win_cnt_d = win_cnt_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_grant;
          last_d  = pick_grant;
          sd_we_d = we[pick_grant];
          case (pick_grant)
            PORT_CART: begin
              sd_addr_d = addr1;
              sd_din_d  = dout1;
            end
            PORT_LOAD: begin
              sd_addr_d = addr2;
              sd_din_d  = dout2;
            end
            default: begin
              sd_addr_d = addr0;
              sd_din_d  = dout0;
            end
          endcase
          // Registered so the request pulse lines up with the ISSUE clock
          sd_req_d = 1'b1;
          state_d  = ISSUE;
        end
      end

      ISSUE: begin
        to_cnt_d = '0;
        state_d  = WAIT;
      end

      WAIT: begin
        if (sd_ack || (to_cnt_q == 6'(TIMEOUT - 1))) begin
          // An abandoned access reads back as open bus (0xFF)
          if (!sd_ack)       din_d = 8'hFF;
          else if (!sd_we_q) din_d = sd_dout;
          win_cnt_d       = '0;
          cycle_d         = '0;
          cycle_d[gnt_q]  = 1'b1;
          state_d         = WINDOW;
        end else begin
          to_cnt_d = to_cnt_q + 6'd1;
        end
      end

      WINDOW: begin
        if (win_cnt_q == 6'(WIN_LEN - 1)) begin
          cycle_d = '0;
          state_d = GAP;
        end else begin
          win_cnt_d = win_cnt_q + 6'd1;
        end
      end

      GAP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      last_q    <= PORT_LOAD;
      gnt_q     <= PORT_REU;
      cycle_q   <= '0;
      din_q     <= 8'hFF;
      sd_req_q  <= 1'b0;
      sd_addr_q <= '0;
      sd_we_q   <= 1'b0;
      sd_din_q  <= '0;
      to_cnt_q  <= '0;
      win_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      cycle_q   <= cycle_d;
      din_q     <= din_d;
      sd_req_q  <= sd_req_d;
      sd_addr_q <= sd_addr_d;
      sd_we_q   <= sd_we_d;
      sd_din_q  <= sd_din_d;
      to_cnt_q  <= to_cnt_d;
      win_cnt_q <= win_cnt_d;
    end
  end

  assign cycle   = cycle_q;
  assign din     = din_q;
  assign sd_req  = sd_req_q;
  assign sd_addr = sd_addr_q;
  assign sd_we   = sd_we_q;
  assign sd_din  = sd_din_q;

endmodule
